// File: rtl/packet_tx_reader_pkg.sv
// Shared definitions for the packet transmit reader.
// Holds the FSM state encoding, the fixed framing bytes, the default widths
// shared with the receive-side packet store, and a small helper for sizing.
package packet_tx_reader_pkg;

  // Default widths, identical to the receive-side store so both sides agree
  // on the packet memory layout and the length FIFO word.
  localparam int ADDR_W = 14;
  localparam int LEN_W  = 11;

  // Framing bytes.
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Transmit FSM states. The state names describe what is on the TX outputs
  // during the current cycle.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_IPG  = 3'd4
  } tx_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/packet_tx_reader_tx_frame_counter.sv
// tx_frame_counter: loadable down-counter with a terminal flag.
// Shared by the preamble, data and inter-packet-gap phases of the TX FSM.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  number of cycles in the phase being entered
//   dec_i       decrement by one (saturates at zero)
//   last_o      high while the count is 1, i.e. the final cycle of a phase
module tx_frame_counter #(
  parameter int P_W = 11
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic [P_W-1:0] load_val_i,
  input  logic           dec_i,
  output logic           last_o
);

  logic [P_W-1:0] cnt_q;
  logic [P_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == P_W'(1));

endmodule

// File: rtl/packet_tx_reader.sv
// packet_tx_reader: pops packet lengths from the length FIFO, fetches the
// packet bytes from packet memory and serialises each packet onto an 8-bit
// MII-style TX interface as preamble, SFD, data, then an inter-packet gap.
// Ports:
//   iclk          clock (rising edge)
//   i_rst_n       asynchronous active-low reset
//   i_en          transmit enable, only looked at while idle
//   i_len_empty   length FIFO empty flag
//   i_len_data    length FIFO head word (first-word-fall-through)
//   o_len_rd      one-cycle FIFO pop strobe
//   o_mem_addr    packet memory read address
//   i_mem_data    packet memory read data, one cycle after o_mem_addr
//   o_tx_en       transmit enable to PHY
//   o_txd         transmit data
//   o_busy        high whenever the FSM is not idle
//   o_frame_done  one-cycle pulse on the first IPG cycle
//   o_rd_ptr      base address of the next packet in memory
//   o_dbg_state   current FSM state
//
// Length FIFO handshake: the head word is valid whenever i_len_empty=0.
// o_len_rd is high for exactly one cycle, and in that cycle the head word is
// both consumed by the FIFO and captured here; a pop is only ever issued
// after seeing i_len_empty=0, and the FIFO cannot empty itself without a pop.
//
// Every output is a register. The state register therefore describes what
// the TX outputs show in the current cycle, and the next-state logic computes
// the outputs for the following cycle.
module packet_tx_reader
  import packet_tx_reader_pkg::*;
#(
  parameter int P_ADDR_W  = ADDR_W,
  parameter int P_LEN_W   = LEN_W,
  parameter int P_PRE_LEN = 7,
  parameter int P_IPG     = 12
) (
  input  logic                iclk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_len_empty,
  input  logic [P_LEN_W-1:0]  i_len_data,
  output logic                o_len_rd,
  output logic [P_ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]          i_mem_data,
  output logic                o_tx_en,
  output logic [7:0]          o_txd,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic [P_ADDR_W-1:0] o_rd_ptr,
  output logic [2:0]          o_dbg_state
);

  // One counter serves all timed phases, so it is sized for the longest.
  localparam int CNT_W = max_int(P_LEN_W,
                                 max_int($clog2(P_PRE_LEN + 1), $clog2(P_IPG + 1)));

  tx_state_e           state_q, state_d;
  logic [P_LEN_W-1:0]  len_q, len_d;
  logic [P_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_ADDR_W-1:0] addr_q, addr_d;
  logic                len_rd_q, len_rd_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                cnt_dec;
  logic                cnt_last;

  tx_frame_counter #(
    .P_W (CNT_W)
  ) u_cnt (
    .clk_i      (iclk),
    .rst_ni     (i_rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rd_ptr_d     = rd_ptr_q;
    addr_d       = addr_q;
    len_rd_d     = 1'b0;
    tx_en_d      = 1'b0;
    txd_d        = 8'h00;
    frame_done_d = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (len_rd_q) begin
          // Pop cycle: capture the head word; zero-length entries are dropped.
          len_d = i_len_data;
          if (i_len_data != '0) begin
            state_d      = ST_PRE;
            tx_en_d      = 1'b1;
            txd_d        = PREAMBLE_BYTE;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(P_PRE_LEN);
            addr_d       = rd_ptr_q;
          end
        end else if (i_en && !i_len_empty) begin
          len_rd_d = 1'b1;
        end
      end

      ST_PRE: begin
        tx_en_d = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_last) begin
          // The packet base address is presented during the last preamble
          // cycle, so byte 0 is back from memory in the SFD cycle, exactly
          // when the first data byte must be registered.
          state_d = ST_SFD;
          txd_d   = SFD_BYTE;
          addr_d  = addr_q + 1'b1;
        end else begin
          txd_d   = PREAMBLE_BYTE;
        end
      end

      ST_SFD: begin
        state_d      = ST_DATA;
        tx_en_d      = 1'b1;
        txd_d        = i_mem_data;
        addr_d       = addr_q + 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(len_q);
      end

      ST_DATA: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d      = ST_IPG;
          frame_done_d = 1'b1;
          rd_ptr_d     = rd_ptr_q + P_ADDR_W'(len_q);
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(P_IPG);
        end else begin
          // Reads run one byte ahead; the final over-fetch is never used.
          tx_en_d = 1'b1;
          txd_d   = i_mem_data;
          addr_d  = addr_q + 1'b1;
        end
      end

      ST_IPG: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      rd_ptr_q     <= '0;
      addr_q       <= '0;
      len_rd_q     <= 1'b0;
      tx_en_q      <= 1'b0;
      txd_q        <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_ptr_q     <= rd_ptr_d;
      addr_q       <= addr_d;
      len_rd_q     <= len_rd_d;
      tx_en_q      <= tx_en_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_len_rd     = len_rd_q;
  assign o_mem_addr   = addr_q;
  assign o_tx_en      = tx_en_q;
  assign o_txd        = txd_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_rd_ptr     = rd_ptr_q;
  assign o_dbg_state  = state_q;

endmodule

// File: doc/packet_tx_reader.md
Name: packet_tx_reader

Overview:
- Read-side counterpart of the receive packet store: pops one packet length from the length FIFO and fetches that many bytes from the packet memory.
- Serialises each packet onto an 8-bit MII-style transmit interface, framed by preamble and SFD and followed by an inter-packet gap.
- Sits between the length FIFO / packet reg_file read ports and the TX PHY side.
- Keeps its own circular read pointer, which tracks the writer's contiguous packet layout.

Parameters:
- P_ADDR_W, 14, packet memory address width; read pointer wraps modulo 2^P_ADDR_W.
- P_LEN_W, 11, length FIFO word width (max packet 2047 bytes).
- P_PRE_LEN, 7, number of 0x55 preamble bytes.
- P_IPG, 12, idle cycles after each frame.

Ports:
- iclk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  transmit enable; sampled only in IDLE.
- i_len_empty  in  1  length FIFO empty flag.
- i_len_data  in  P_LEN_W  length FIFO head word; first-word-fall-through, valid whenever i_len_empty=0.
- o_len_rd  out  1  one-cycle FIFO pop strobe.
- o_mem_addr  out  P_ADDR_W  packet memory read address.
- i_mem_data  in  8  packet memory read data; valid exactly one cycle after o_mem_addr is presented.
- o_tx_en  out  1  transmit enable to PHY.
- o_txd  out  8  transmit data.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle pulse on the first IPG cycle.
- o_rd_ptr  out  P_ADDR_W  current packet base pointer (status).

Behaviour:
- Reset (async, i_rst_n=0) forces all outputs to 0, state to IDLE and rd_ptr to 0 immediately. A frame in flight is truncated: o_tx_en drops without SFD or data completion.
- All outputs are registered.
- States: IDLE, PRE, SFD, DATA, IPG.
- IDLE:
  - If i_en=1 and i_len_empty=0, assert o_len_rd for exactly one cycle and latch len=i_len_data in that same cycle.
  - If len=0, pop and discard it: no frame, stay IDLE, rd_ptr unchanged.
  - If len>0, go to PRE.
- PRE: P_PRE_LEN cycles with o_tx_en=1, o_txd=0x55.
- SFD: 1 cycle with o_tx_en=1, o_txd=0xD5.
- DATA:
  - len cycles with o_tx_en=1; byte i (0-based) has o_txd = mem[(rd_ptr+i) mod 2^P_ADDR_W].
  - No gaps, no idle bubble between SFD and byte 0.
  - Address issue is prefetched as needed to meet the 1-cycle memory latency.
  - o_mem_addr increments by 1 per byte and wraps 2^P_ADDR_W-1 -> 0.
- IPG:
  - Entered the cycle after the last data byte; o_tx_en=0 and o_txd=0x00 for P_IPG cycles; o_frame_done=1 on the first IPG cycle.
  - rd_ptr updates to (rd_ptr+len) mod 2^P_ADDR_W on the first IPG cycle.
  - After P_IPG cycles, return to IDLE.
- Latency: from the o_len_rd cycle, o_tx_en rises next cycle. The frame occupies P_PRE_LEN+1+len cycles; the next o_len_rd can occur no earlier than P_IPG cycles after o_tx_en falls.
- i_en falling mid-frame has no effect; the current frame and IPG complete.
- FIFO going non-empty while not in IDLE has no effect until IDLE is reached.
- o_len_rd is never asserted while i_len_empty=1.
- o_tx_en is never high outside PRE/SFD/DATA.
- Length arithmetic is unsigned P_LEN_W; the byte counter counts down from len to 1.

Decomposition:
- Shared package holds:
  - state enum (IDLE, PRE, SFD, DATA, IPG);
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - default widths (ADDR_W=14, LEN_W=11), shared with the receive-side store.
- One natural sub-module: tx_frame_counter, a loadable down-counter with terminal flag, reused for the PRE, DATA and IPG phases.
- Everything else stays in the top FSM.

Test Plan:
- Single frame: mem[0..3]={A1,B2,C3,D4}, FIFO={4}, i_en=1 -> o_len_rd one pulse; o_txd = 7x55, D5, A1 B2 C3 D4 with o_tx_en=1 for 12 cycles; o_frame_done pulse; 12 idle cycles; o_rd_ptr=4.
- Back-to-back: FIFO={3,2}, mem[0..4]=01..05 -> frame1 data 01 02 03, exactly 12 IPG cycles, frame2 data 04 05; final o_rd_ptr=5.
- Wrap-around: rd_ptr preset via prior frames to 16382, FIFO={4} -> data read from addresses 16382, 16383, 0, 1; o_rd_ptr=2 after.
- Zero length: FIFO={0,2} -> first pop produces no o_tx_en; second pop sends 2-byte frame from address 0.
- Enable gating: FIFO={5}, i_en=0 for 20 cycles -> no o_len_rd, o_busy=0. Raise i_en, then drop it after the SFD -> full 5-byte frame still sent.
- Reset mid-DATA: assert i_rst_n=0 during byte 2 of a 6-byte frame -> o_tx_en=0, o_busy=0, o_rd_ptr=0 in the same cycle. After release with FIFO empty, outputs stay idle.
